register_file_sb: RTL and testbench

Parametrised register file with two write ports, same-cycle write-to-read forwarding, and a per-register pending-write scoreboard. It generalises the single-port 32x32 register file in width and depth. It adds a second, late write port that returns multi-cycle results such as loads, and busy tracking that the decode stage uses to stall on RAW hazards. It sits between decode (read and set ports) and writeback (write ports) in the datapath.

---
 rtl/register_file_sb.sv | 61 ++++++
 tb/tb_register_file_sb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: dual-write register file with same-cycle forwarding and a pending-write scoreboard
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              SET_EN,
  input  logic [ADDR_W-1:0] SET_A,
  output logic [ADDR_W:0]   PEND_CNT,
  output logic              ERR
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic we3_e, we4_e, set_e, inc, dec;
  assign we3_e = WE3 && !(ZERO_REG && A3 == '0);
  assign we4_e = WE4 && !(ZERO_REG && A4 == '0);
  assign set_e = SET_EN && !(ZERO_REG && SET_A == '0);
  assign inc   = set_e && !busy[SET_A];
  assign dec   = we4_e && busy[A4] && !(set_e && SET_A == A4);
  // read ports: zero register first, then the younger port 3, then port 4, then the array
  always_comb begin
    RD1   = !reset_n || (ZERO_REG && A1 == '0) ? '0 : we3_e && A3 == A1 ? WD3 : we4_e && A4 == A1 ? WD4 : regs[A1];
    RD2   = !reset_n || (ZERO_REG && A2 == '0) ? '0 : we3_e && A3 == A2 ? WD3 : we4_e && A4 == A2 ? WD4 : regs[A2];
    BUSY1 = reset_n && busy[A1] && !(we4_e && A4 == A1);
    BUSY2 = reset_n && busy[A2] && !(we4_e && A4 == A2);
  end
  // state update: port 3 overrides port 4, a set overrides a clear on the same register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      PEND_CNT <= '0;
      ERR      <= 1'b0;
    end else begin
      if (we4_e) begin
        regs[A4] <= WD4;
        busy[A4] <= 1'b0;
      end
      if (we3_e) regs[A3] <= WD3;
      if (set_e) busy[SET_A] <= 1'b1;
      PEND_CNT <= PEND_CNT + CW'(inc) - CW'(dec);
      if (we4_e && !busy[A4]) ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: scoreboard bench with a behavioural model of the register file
module tb_register_file_sb;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] A1, A2, A3, A4, SET_A;
  logic [31:0] RD1, RD2, WD3, WD4;
  logic BUSY1, BUSY2, WE3, WE4, SET_EN, ERR;
  logic [5:0] PEND_CNT;
  typedef struct {
    string tag;
    logic [31:0] rd1, rd2;
    logic b1, b2, err;
    logic [5:0] pc;
  } exp_t;
  exp_t q[$];
  logic [31:0] mregs [32];
  bit mbusy [32];
  bit merr;
  int errors = 0;
  int checks = 0;
  register_file_sb dut (
    .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .WE3(WE3), .A3(A3), .WD3(WD3),
    .WE4(WE4), .A4(A4), .WD4(WD4), .SET_EN(SET_EN), .SET_A(SET_A),
    .PEND_CNT(PEND_CNT), .ERR(ERR)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mread(logic [4:0] a);
    if (!reset_n || a == 0) return 32'h0;
    if (WE3 && A3 == a) return WD3;
    if (WE4 && A4 == a) return WD4;
    return mregs[a];
  endfunction
  function automatic logic mbusy_out(logic [4:0] a);
    return reset_n && a != 0 && mbusy[a] && !(WE4 && A4 == a);
  endfunction
  function automatic logic [5:0] mcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
    return 6'(n);
  endfunction
  task automatic model_edge();
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 0;
        mbusy[i] = 0;
      end
      merr = 0;
    end else begin
      if (WE4 && A4 != 0) begin
        if (!mbusy[A4]) merr = 1;
        mregs[A4] = WD4;
        mbusy[A4] = 0;
      end
      if (WE3 && A3 != 0) mregs[A3] = WD3;
      if (SET_EN && SET_A != 0) mbusy[SET_A] = 1;
    end
  endtask
  task automatic idle();
    WE3 = 0; WE4 = 0; SET_EN = 0;
    A3 = 0; A4 = 0; SET_A = 0; WD3 = 0; WD4 = 0;
  endtask
  task automatic cyc(string tag);
    exp_t e;
    e.tag = tag;
    e.rd1 = mread(A1);
    e.rd2 = mread(A2);
    e.b1  = mbusy_out(A1);
    e.b2  = mbusy_out(A2);
    e.pc  = mcount();
    e.err = merr;
    q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: every queued expectation is compared against the DUT mid-cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " rd1"}, RD1, e.rd1);
      chk({e.tag, " rd2"}, RD2, e.rd2);
      chk({e.tag, " busy1"}, 32'(BUSY1), 32'(e.b1));
      chk({e.tag, " busy2"}, 32'(BUSY2), 32'(e.b2));
      chk({e.tag, " pend_cnt"}, 32'(PEND_CNT), 32'(e.pc));
      chk({e.tag, " err"}, 32'(ERR), 32'(e.err));
    end
  end
  function automatic logic [4:0] ra();
    return $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction
  initial begin
    idle();
    reset_n = 0; A1 = 0; A2 = 0;
    @(posedge clk);
    model_edge();
    #1;
    A2 = 5'd13;
    cyc("reset_hold");
    reset_n = 1; WE3 = 1; A3 = 5; WD3 = 32'hDEADBEEF;
    cyc("write_r5");
    idle(); reset_n = 0; A1 = 5; A2 = 5'd22;
    cyc("reset_r5");
    reset_n = 1;
    cyc("after_reset_r5");
    WE3 = 1; A3 = 7; WD3 = 32'h11; WE4 = 1; A4 = 7; WD4 = 32'h22; A1 = 7;
    cyc("priority_r7");
    idle();
    cyc("after_priority_r7");
    WE3 = 1; A3 = 0; WD3 = 32'hFFFFFFFF; SET_EN = 1; SET_A = 0; A1 = 0;
    cyc("zero_reg");
    idle();
    cyc("after_zero_reg");
    SET_EN = 1; SET_A = 3; A1 = 3;
    cyc("set_r3");
    idle();
    cyc("busy_r3");
    WE4 = 1; A4 = 3; WD4 = 32'hAB;
    cyc("clear_r3");
    idle();
    cyc("after_clear_r3");
    SET_EN = 1; SET_A = 4; A1 = 4;
    cyc("set_r4");
    SET_EN = 1; SET_A = 4; WE4 = 1; A4 = 4; WD4 = 32'h44;
    cyc("collide_r4");
    idle();
    cyc("after_collide_r4");
    reset_n = 0;
    cyc("reset_err");
    reset_n = 1; WE4 = 1; A4 = 9; WD4 = 32'h99; A1 = 9;
    cyc("err_r9");
    idle();
    cyc("err_set");
    cyc("err_sticky");
    for (int i = 1; i < 32; i++) begin
      SET_EN = 1; SET_A = 5'(i); A1 = 5'(i); A2 = 5'(i - 1);
      cyc("fill");
    end
    idle();
    cyc("fill_done");
    for (int n = 0; n < 3000; n++) begin
      reset_n = $urandom_range(0, 99) != 0;
      WE3 = 1'($urandom_range(0, 1)); A3 = ra(); WD3 = $urandom;
      WE4 = 1'($urandom_range(0, 1)); A4 = ra(); WD4 = $urandom;
      SET_EN = 1'($urandom_range(0, 1)); SET_A = ra();
      A1 = $urandom_range(0, 1) ? A4 : ra();
      A2 = $urandom_range(0, 1) ? A3 : ra();
      cyc("random");
    end
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
